serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH itself so it never wraps during RUN.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder used as the serial datapath slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit position per RUN cycle, LSB first, result
// published in a single-cycle DONE state and held until the next one.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] a_shift;

  full_adder u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // Sum bits are shifted into the MSB end of the A register as A drains out,
  // so after WIDTH shifts the register holds the complete sum.
  generate
    if (WIDTH == 1) begin : g_w1
      assign a_shift = fa_sum;
    end else begin : g_wn
      assign a_shift = {fa_sum, a_reg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            a_reg     <= a_i;
            b_reg     <= b_i;
            carry_reg <= cin_i;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_shift;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_cout;
          cnt_reg   <= cnt_reg + CW'(1);
          // On the MSB, carry_reg is the carry into bit WIDTH-1.
          if (last_bit) begin
            sum_reg  <= a_shift;
            cout_reg <= fa_cout;
            ovf_reg  <= SIGNED_MODE ? (carry_reg ^ fa_cout) : fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_o  = sum_reg;
  assign cout_o = cout_reg;
  assign ovf_o  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit unsigned, 8-bit signed and 1-bit instances.
module tb_serial_adder;

  typedef struct {
    int         inst;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_d [3];
  logic [7:0] b_d [3];
  logic       cin_d [3];
  logic       start_d [3];
  logic       ready_w [3];
  logic       done_w [3];
  logic       cout_w [3];
  logic       ovf_w [3];
  logic [7:0] sum_w [3];
  logic [7:0] sum_u8;
  logic [7:0] sum_s8;
  logic       sum_u1;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc;
  int   checks;
  int   failures;

  serial_adder #(.WIDTH(8), .SIGNED_MODE(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .start_i(start_d[0]), .a_i(a_d[0]), .b_i(b_d[0]),
    .cin_i(cin_d[0]), .ready_o(ready_w[0]), .done_o(done_w[0]), .sum_o(sum_u8),
    .cout_o(cout_w[0]), .ovf_o(ovf_w[0])
  );

  serial_adder #(.WIDTH(8), .SIGNED_MODE(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start_i(start_d[1]), .a_i(a_d[1]), .b_i(b_d[1]),
    .cin_i(cin_d[1]), .ready_o(ready_w[1]), .done_o(done_w[1]), .sum_o(sum_s8),
    .cout_o(cout_w[1]), .ovf_o(ovf_w[1])
  );

  serial_adder #(.WIDTH(1), .SIGNED_MODE(1'b0)) u_u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_d[2]), .a_i(a_d[2][0]), .b_i(b_d[2][0]),
    .cin_i(cin_d[2]), .ready_o(ready_w[2]), .done_o(done_w[2]), .sum_o(sum_u1),
    .cout_o(cout_w[2]), .ovf_o(ovf_w[2])
  );

  assign sum_w[0] = sum_u8;
  assign sum_w[1] = sum_s8;
  assign sum_w[2] = {7'd0, sum_u1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input int inst);
    return (inst == 2) ? 1 : 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: pops one expectation per done_o pulse, including its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (done_w[i]) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done inst=%0d actual_sum=%0h required=no_done", i, sum_w[i]);
          end else begin
            mon_e = sb_q.pop_front();
            $display("txn inst=%0d sum=%02h cout=%0b ovf=%0b cyc=%0d", i, sum_w[i], cout_w[i], ovf_w[i], cyc);
            chk("done_inst", 32'(i), 32'(mon_e.inst));
            chk("sum", 32'(sum_w[i]), 32'(mon_e.sum));
            chk("cout", 32'(cout_w[i]), 32'(mon_e.cout));
            chk("ovf", 32'(ovf_w[i]), 32'(mon_e.ovf));
            chk("done_cycle", 32'(cyc), 32'(mon_e.due));
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int inst, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    while (!ready_w[inst] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_w[inst]) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout inst=%0d actual=0 required=1", inst);
      return;
    end
    a_d[inst]     = a;
    b_d[inst]     = b;
    cin_d[inst]   = c;
    start_d[inst] = 1'b1;
    sb_q.push_back('{inst, es, ec, eo, cyc + 1 + width_of(inst)});
    @(negedge clk);
    start_d[inst] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  logic [7:0] fa_sum_tab;
  logic [7:0] fa_cout_tab;

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_d[i] = 8'd0; b_d[i] = 8'd0; cin_d[i] = 1'b0; start_d[i] = 1'b0;
    end
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(ready_w[i]), 32'd1);
      chk("rst_done", 32'(done_w[i]), 32'd0);
      chk("rst_sum", 32'(sum_w[i]), 32'd0);
      chk("rst_cout", 32'(cout_w[i]), 32'd0);
      chk("rst_ovf", 32'(ovf_w[i]), 32'd0);
    end

    // Start issued in the same cycle reset is released: first edge accepts it.
    rst_n = 1'b1;
    issue(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    issue(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    issue(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    issue(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1);
    issue(0, 8'hC0, 8'h50, 1'b0, 8'h10, 1'b1, 1'b1);
    drain();
    chk("hold_sum", 32'(sum_w[0]), 32'h10);

    // Abort: reset during the third RUN cycle.
    issue(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    void'(sb_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready_w[0]), 32'd1);
    chk("abort_done", 32'(done_w[0]), 32'd0);
    chk("abort_sum", 32'(sum_w[0]), 32'd0);
    chk("abort_cout", 32'(cout_w[0]), 32'd0);
    chk("abort_ovf", 32'(ovf_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0);
    drain();
    repeat (12) @(negedge clk);

    // start_i held high with operands churning; only the latched pair counts.
    a_d[0] = 8'h12; b_d[0] = 8'h34; cin_d[0] = 1'b0; start_d[0] = 1'b1;
    sb_q.push_back('{0, 8'h46, 1'b0, 1'b0, cyc + 1 + 8});
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'(ready_w[0]), 32'd0);
      a_d[0]   = 8'($urandom);
      b_d[0]   = 8'($urandom);
      cin_d[0] = 1'($urandom);
    end
    @(negedge clk);
    chk("reissue_ready", 32'(ready_w[0]), 32'd1);
    a_d[0] = 8'h01; b_d[0] = 8'h02; cin_d[0] = 1'b0;
    sb_q.push_back('{0, 8'h03, 1'b0, 1'b0, cyc + 1 + 8});
    @(negedge clk);
    start_d[0] = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("hold_sum2", 32'(sum_w[0]), 32'h03);

    // Signed overflow rule.
    issue(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue(1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    issue(1, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
    issue(1, 8'hFE, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b0);
    drain();

    // WIDTH=1 full-adder truth table, index = {a,b,cin}.
    fa_sum_tab  = 8'b1001_0110;
    fa_cout_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      issue(2, {7'd0, i[2]}, {7'd0, i[1]}, i[0],
            {7'd0, fa_sum_tab[i]}, fa_cout_tab[i], fa_cout_tab[i]);
    end
    drain();

    chk("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
